// File: rtl/ppu_pkg.sv
// Shared definitions for the CPU-facing PPU register block: register indices,
// control/status bit positions and address increment steps.
package ppu_pkg;

  localparam int unsigned D_W  = 8;
  localparam int unsigned V_W  = 15;
  localparam int unsigned A_W  = 14;
  localparam int unsigned FX_W = 3;

  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_MASK    = 3'd1,
    REG_STATUS  = 3'd2,
    REG_OAMADDR = 3'd3,
    REG_OAMDATA = 3'd4,
    REG_SCROLL  = 3'd5,
    REG_ADDR    = 3'd6,
    REG_DATA    = 3'd7
  } reg_idx_e;

  localparam int unsigned CTRL_INC32  = 2;
  localparam int unsigned CTRL_NMI_EN = 7;
  localparam int unsigned STAT_OVF    = 5;
  localparam int unsigned STAT_SPR0   = 6;
  localparam int unsigned STAT_VBLANK = 7;

  localparam int unsigned INC_ACROSS = 1;
  localparam int unsigned INC_DOWN   = 32;

  function automatic logic [D_W-1:0] status_byte(input logic vblank,
                                                 input logic spr0,
                                                 input logic ovf);
    logic [D_W-1:0] s;
    s              = '0;
    s[STAT_VBLANK] = vblank;
    s[STAT_SPR0]   = spr0;
    s[STAT_OVF]    = ovf;
    return s;
  endfunction

endpackage

// File: rtl/ppu_scroll_addr.sv
// Scroll/address state: current address v, temporary address t, fine X and the
// shared first/second-write toggle used by $2005 and $2006.
module ppu_scroll_addr
  import ppu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_ctrl,
  input  logic            wr_scroll,
  input  logic            wr_addr,
  input  logic            status_rd,
  input  logic            inc_en,
  input  logic            inc_down,
  input  logic [D_W-1:0]  wdata,
  output logic [V_W-1:0]  vram_v,
  output logic [V_W-1:0]  vram_t,
  output logic [FX_W-1:0] fine_x
);

  logic [V_W-1:0]  v_q, v_d;
  logic [V_W-1:0]  t_q, t_d;
  logic [FX_W-1:0] fx_q, fx_d;
  logic            w_q, w_d;

  always_comb begin
    v_d  = v_q;
    t_d  = t_q;
    fx_d = fx_q;
    w_d  = w_q;

    if (wr_ctrl) t_d[11:10] = wdata[1:0];

    if (wr_scroll) begin
      if (!w_q) begin
        t_d[4:0] = wdata[7:3];
        fx_d     = wdata[2:0];
        w_d      = 1'b1;
      end else begin
        t_d[14:12] = wdata[2:0];
        t_d[9:5]   = wdata[7:3];
        w_d        = 1'b0;
      end
    end

    // Second $2006 write copies the freshly completed t into v
    if (wr_addr) begin
      if (!w_q) begin
        t_d[13:8] = wdata[5:0];
        t_d[14]   = 1'b0;
        w_d       = 1'b1;
      end else begin
        t_d[7:0] = wdata;
        v_d      = t_d;
        w_d      = 1'b0;
      end
    end

    if (inc_en) v_d = v_q + (inc_down ? V_W'(INC_DOWN) : V_W'(INC_ACROSS));

    if (status_rd) w_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q  <= '0;
      t_q  <= '0;
      fx_q <= '0;
      w_q  <= 1'b0;
    end else begin
      v_q  <= v_d;
      t_q  <= t_d;
      fx_q <= fx_d;
      w_q  <= w_d;
    end
  end

  assign vram_v = v_q;
  assign vram_t = t_q;
  assign fine_x = fx_q;

endmodule

// File: rtl/ppu_reg_responder.sv
// CPU register-bus responder for $2000-$2007: commit detection, register file,
// status/NMI, OAM and VRAM port strobes and the PPUDATA read buffer.
module ppu_reg_responder
  import ppu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ppu_reg_cs,
  input  logic [2:0]      ppu_reg_addr,
  input  logic            reg_we,
  input  logic [D_W-1:0]  reg_data_in,
  output logic [D_W-1:0]  reg_data_out,
  output logic            nmi,
  input  logic            vblank_set,
  input  logic            vblank_clr,
  input  logic            sprite0_hit,
  input  logic            sprite_ovf,
  output logic [D_W-1:0]  ppuctrl,
  output logic [D_W-1:0]  ppumask,
  output logic [V_W-1:0]  vram_v,
  output logic [V_W-1:0]  vram_t,
  output logic [FX_W-1:0] fine_x,
  output logic [A_W-1:0]  vram_addr,
  output logic [D_W-1:0]  vram_wr_data,
  output logic            vram_we,
  output logic            vram_re,
  input  logic [D_W-1:0]  vram_rd_data,
  output logic [D_W-1:0]  oam_addr,
  output logic [D_W-1:0]  oam_wr_data,
  output logic            oam_we,
  input  logic [D_W-1:0]  oam_rd_data
);

  // Registered active-high select; resetting it to 1 means a cs held low
  // across reset release looks like an ongoing access, not a new one.
  logic           cs_sel_q, cs_sel_d;
  logic [D_W-1:0] ppuctrl_q, ppuctrl_d;
  logic [D_W-1:0] ppumask_q, ppumask_d;
  logic           vblank_q, vblank_d;
  logic [D_W-1:0] rdbuf_q, rdbuf_d;
  logic           rd_pending_q, rd_pending_d;
  logic [D_W-1:0] oam_addr_q, oam_addr_d;
  logic [D_W-1:0] oam_wr_data_q, oam_wr_data_d;
  logic           oam_we_q, oam_we_d;
  logic [D_W-1:0] vram_wr_data_q, vram_wr_data_d;
  logic           vram_we_q, vram_we_d;
  logic           vram_re_q, vram_re_d;
  logic [A_W-1:0] vram_addr_q, vram_addr_d;
  logic [D_W-1:0] reg_data_out_q, reg_data_out_d;
  logic           nmi_q, nmi_d;

  logic     commit_c, wr_c, rd_c;
  logic     wr_ctrl_c, wr_scroll_c, wr_addr_c, status_rd_c, inc_c;
  reg_idx_e reg_idx_c;

  always_comb begin
    reg_idx_c   = reg_idx_e'(ppu_reg_addr);
    commit_c    = ~cs_sel_q & ~ppu_reg_cs;
    wr_c        = commit_c & reg_we;
    rd_c        = commit_c & ~reg_we;
    wr_ctrl_c   = wr_c && (reg_idx_c == REG_CTRL);
    wr_scroll_c = wr_c && (reg_idx_c == REG_SCROLL);
    wr_addr_c   = wr_c && (reg_idx_c == REG_ADDR);
    status_rd_c = rd_c && (reg_idx_c == REG_STATUS);
    inc_c       = commit_c && (reg_idx_c == REG_DATA);
  end

  ppu_scroll_addr u_scroll_addr (
    .clk       (clk),
    .reset     (reset),
    .wr_ctrl   (wr_ctrl_c),
    .wr_scroll (wr_scroll_c),
    .wr_addr   (wr_addr_c),
    .status_rd (status_rd_c),
    .inc_en    (inc_c),
    .inc_down  (ppuctrl_q[CTRL_INC32]),
    .wdata     (reg_data_in),
    .vram_v    (vram_v),
    .vram_t    (vram_t),
    .fine_x    (fine_x)
  );

  always_comb begin
    cs_sel_d       = ~ppu_reg_cs;
    ppuctrl_d      = ppuctrl_q;
    ppumask_d      = ppumask_q;
    rdbuf_d        = rdbuf_q;
    rd_pending_d   = vram_re_q;
    oam_addr_d     = oam_addr_q;
    oam_wr_data_d  = oam_wr_data_q;
    oam_we_d       = 1'b0;
    vram_wr_data_d = vram_wr_data_q;
    vram_we_d      = 1'b0;
    vram_re_d      = 1'b0;
    // Lags v by one cycle so the strobe cycle presents the pre-increment address
    vram_addr_d    = vram_v[A_W-1:0];
    reg_data_out_d = reg_data_out_q;

    // VRAM data arrives the cycle after vram_re
    if (rd_pending_q) rdbuf_d = vram_rd_data;
    if (oam_we_q) oam_addr_d = oam_addr_q + 8'd1;

    if (wr_c) begin
      case (reg_idx_c)
        REG_CTRL:    ppuctrl_d = reg_data_in;
        REG_MASK:    ppumask_d = reg_data_in;
        REG_OAMADDR: oam_addr_d = reg_data_in;
        REG_OAMDATA: begin
          oam_we_d      = 1'b1;
          oam_wr_data_d = reg_data_in;
        end
        REG_DATA: begin
          vram_we_d      = 1'b1;
          vram_wr_data_d = reg_data_in;
        end
        default: ;
      endcase
    end

    if (rd_c) begin
      case (reg_idx_c)
        REG_STATUS:  reg_data_out_d = status_byte(vblank_q, sprite0_hit, sprite_ovf);
        REG_OAMDATA: reg_data_out_d = oam_rd_data;
        REG_DATA: begin
          reg_data_out_d = rdbuf_q;
          vram_re_d      = 1'b1;
        end
        default: ;
      endcase
    end

    // Clear beats set; a STATUS read suppresses a coincident set
    vblank_d = vblank_q;
    if (vblank_set) vblank_d = 1'b1;
    if (status_rd_c || vblank_clr) vblank_d = 1'b0;

    nmi_d = ~(vblank_d & ppuctrl_d[CTRL_NMI_EN]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sel_q       <= 1'b1;
      ppuctrl_q      <= '0;
      ppumask_q      <= '0;
      vblank_q       <= 1'b0;
      rdbuf_q        <= '0;
      rd_pending_q   <= 1'b0;
      oam_addr_q     <= '0;
      oam_wr_data_q  <= '0;
      oam_we_q       <= 1'b0;
      vram_wr_data_q <= '0;
      vram_we_q      <= 1'b0;
      vram_re_q      <= 1'b0;
      vram_addr_q    <= '0;
      reg_data_out_q <= '0;
      nmi_q          <= 1'b1;
    end else begin
      cs_sel_q       <= cs_sel_d;
      ppuctrl_q      <= ppuctrl_d;
      ppumask_q      <= ppumask_d;
      vblank_q       <= vblank_d;
      rdbuf_q        <= rdbuf_d;
      rd_pending_q   <= rd_pending_d;
      oam_addr_q     <= oam_addr_d;
      oam_wr_data_q  <= oam_wr_data_d;
      oam_we_q       <= oam_we_d;
      vram_wr_data_q <= vram_wr_data_d;
      vram_we_q      <= vram_we_d;
      vram_re_q      <= vram_re_d;
      vram_addr_q    <= vram_addr_d;
      reg_data_out_q <= reg_data_out_d;
      nmi_q          <= nmi_d;
    end
  end

  assign reg_data_out = reg_data_out_q;
  assign nmi          = nmi_q;
  assign ppuctrl      = ppuctrl_q;
  assign ppumask      = ppumask_q;
  assign vram_addr    = vram_addr_q;
  assign vram_wr_data = vram_wr_data_q;
  assign vram_we      = vram_we_q;
  assign vram_re      = vram_re_q;
  assign oam_addr     = oam_addr_q;
  assign oam_wr_data  = oam_wr_data_q;
  assign oam_we       = oam_we_q;

endmodule

// File: tb/tb_ppu_reg_responder.sv
// Bench for ppu_reg_responder: register-write vector table, VRAM write and
// register-read scoreboards, plus sequences for status, NMI, OAM and reset.
module tb_ppu_reg_responder;
  import ppu_pkg::*;

  logic        clk, reset;
  logic        ppu_reg_cs, reg_we;
  logic [2:0]  ppu_reg_addr;
  logic [7:0]  reg_data_in, reg_data_out;
  logic        nmi, vblank_set, vblank_clr, sprite0_hit, sprite_ovf;
  logic [7:0]  ppuctrl, ppumask;
  logic [14:0] vram_v, vram_t;
  logic [2:0]  fine_x;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wr_data, vram_rd_data;
  logic        vram_we, vram_re;
  logic [7:0]  oam_addr, oam_wr_data, oam_rd_data;
  logic        oam_we;

  ppu_reg_responder dut (
    .clk(clk), .reset(reset), .ppu_reg_cs(ppu_reg_cs), .ppu_reg_addr(ppu_reg_addr),
    .reg_we(reg_we), .reg_data_in(reg_data_in), .reg_data_out(reg_data_out), .nmi(nmi),
    .vblank_set(vblank_set), .vblank_clr(vblank_clr), .sprite0_hit(sprite0_hit),
    .sprite_ovf(sprite_ovf), .ppuctrl(ppuctrl), .ppumask(ppumask), .vram_v(vram_v),
    .vram_t(vram_t), .fine_x(fine_x), .vram_addr(vram_addr), .vram_wr_data(vram_wr_data),
    .vram_we(vram_we), .vram_re(vram_re), .vram_rd_data(vram_rd_data), .oam_addr(oam_addr),
    .oam_wr_data(oam_wr_data), .oam_we(oam_we), .oam_rd_data(oam_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM with one-cycle read latency, OAM with combinational read
  logic [7:0] vmem [0:16383];
  logic [7:0] omem [0:255];
  always @(posedge clk) begin
    if (vram_we) vmem[vram_addr] <= vram_wr_data;
    if (vram_re) vram_rd_data <= vmem[vram_addr];
    if (oam_we) omem[oam_addr] <= oam_wr_data;
  end
  assign oam_rd_data = omem[oam_addr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {logic [13:0] a; logic [7:0] d;} vwr_t;
  vwr_t       vwr_q[$];
  logic [7:0] rd_q[$];

  always @(negedge clk) begin
    if (!reset && vram_we) begin
      vwr_t e;
      if (vwr_q.size() == 0) chk("vram_we_unexpected", 32'(1), 32'(0));
      else begin
        e = vwr_q.pop_front();
        chk("vram_wr", 32'({vram_addr, vram_wr_data}), 32'(e));
      end
    end
  end

  logic       s_vram_re, s_oam_we, s_nmi;
  logic [13:0] s_vram_addr;
  logic [7:0] s_oam_addr, s_oam_wd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One commit; snapshots strobes at C+1 and leaves 3 cycles between commits
  task automatic access(input logic [2:0] a, input logic we, input logic [7:0] d, input logic vs);
    ppu_reg_cs = 1'b0; ppu_reg_addr = a; reg_we = we; reg_data_in = d; vblank_set = vs;
    tick();
    ppu_reg_cs = 1'b1; vblank_set = 1'b0;
    s_vram_re = vram_re; s_vram_addr = vram_addr; s_nmi = nmi;
    s_oam_we = oam_we; s_oam_addr = oam_addr; s_oam_wd = oam_wr_data;
    if (!we && rd_q.size() > 0) chk($sformatf("rdata_reg%0d", a), 32'(reg_data_out), 32'(rd_q.pop_front()));
    tick();
    tick();
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input logic vs);
    rd_q.push_back(exp);
    access(a, 1'b0, 8'h00, vs);
  endtask

  task automatic wr_data(input logic [7:0] d, input logic [13:0] exp_a);
    vwr_q.push_back(vwr_t'({exp_a, d}));
    access(3'd7, 1'b1, d, 1'b0);
  endtask

  typedef struct {
    logic [2:0] a; logic [7:0] d;
    logic [14:0] ev; logic [14:0] et; logic [2:0] efx; logic [7:0] ectrl;
  } vec_t;
  vec_t tbl [12];

  initial begin
    logic [14:0] prev_v;
    tbl[0]  = '{3'd6, 8'h21, 15'h0000, 15'h2100, 3'd0, 8'h00};
    tbl[1]  = '{3'd6, 8'h08, 15'h2108, 15'h2108, 3'd0, 8'h00};
    tbl[2]  = '{3'd7, 8'h5A, 15'h2109, 15'h2108, 3'd0, 8'h00};
    tbl[3]  = '{3'd5, 8'h7D, 15'h2109, 15'h210F, 3'd5, 8'h00};
    tbl[4]  = '{3'd5, 8'h5E, 15'h2109, 15'h616F, 3'd5, 8'h00};
    tbl[5]  = '{3'd0, 8'h03, 15'h2109, 15'h6D6F, 3'd5, 8'h03};
    tbl[6]  = '{3'd6, 8'h3F, 15'h2109, 15'h3F6F, 3'd5, 8'h03};
    tbl[7]  = '{3'd6, 8'h00, 15'h3F00, 15'h3F00, 3'd5, 8'h03};
    tbl[8]  = '{3'd0, 8'h04, 15'h3F00, 15'h3300, 3'd5, 8'h04};
    tbl[9]  = '{3'd7, 8'hAA, 15'h3F20, 15'h3300, 3'd5, 8'h04};
    tbl[10] = '{3'd0, 8'h00, 15'h3F20, 15'h3300, 3'd5, 8'h00};
    tbl[11] = '{3'd7, 8'hBB, 15'h3F21, 15'h3300, 3'd5, 8'h00};

    reset = 1'b1; ppu_reg_cs = 1'b1; ppu_reg_addr = 3'd0; reg_we = 1'b0; reg_data_in = 8'h00;
    vblank_set = 1'b0; vblank_clr = 1'b0; sprite0_hit = 1'b0; sprite_ovf = 1'b0;
    tick(); tick();
    chk("rst_ppuctrl", 32'(ppuctrl), 32'(0));
    chk("rst_vram_v", 32'(vram_v), 32'(0));
    chk("rst_nmi", 32'(nmi), 32'(1));
    chk("rst_rdata", 32'(reg_data_out), 32'(0));
    #2 reset = 1'b0;
    tick(); tick();

    prev_v = 15'h0000;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].a == 3'd7) wr_data(tbl[i].d, prev_v[13:0]);
      else access(tbl[i].a, 1'b1, tbl[i].d, 1'b0);
      chk($sformatf("row%0d_v", i), 32'(vram_v), 32'(tbl[i].ev));
      chk($sformatf("row%0d_t", i), 32'(vram_t), 32'(tbl[i].et));
      chk($sformatf("row%0d_fx", i), 32'(fine_x), 32'(tbl[i].efx));
      chk($sformatf("row%0d_ctrl", i), 32'(ppuctrl), 32'(tbl[i].ectrl));
      prev_v = tbl[i].ev;
    end

    // Increment by 32
    access(3'd0, 1'b1, 8'h04, 1'b0);
    access(3'd6, 1'b1, 8'h20, 1'b0);
    access(3'd6, 1'b1, 8'h00, 1'b0);
    chk("inc32_start", 32'(vram_v), 32'h2000);
    for (int k = 1; k <= 3; k++) begin
      wr_data(8'(k), 14'(15'h2000 + 15'(32 * (k - 1))));
      chk($sformatf("inc32_v%0d", k), 32'(vram_v), 32'(15'h2000 + 15'(32 * k)));
    end

    // Buffered PPUDATA reads
    access(3'd0, 1'b1, 8'h00, 1'b0);
    access(3'd6, 1'b1, 8'h01, 1'b0);
    access(3'd6, 1'b1, 8'h00, 1'b0);
    wr_data(8'h11, 14'h0100);
    wr_data(8'h22, 14'h0101);
    access(3'd6, 1'b1, 8'h01, 1'b0);
    access(3'd6, 1'b1, 8'h00, 1'b0);
    rd(3'd7, 8'h00, 1'b0);
    chk("rd_vram_re", 32'(s_vram_re), 32'(1));
    chk("rd_vram_addr", 32'(s_vram_addr), 32'h0100);
    chk("rd_v_inc", 32'(vram_v), 32'h0101);
    rd(3'd7, 8'h11, 1'b0);
    rd(3'd7, 8'h22, 1'b0);

    // Status reads
    vblank_set = 1'b1; tick(); vblank_set = 1'b0; tick();
    rd(3'd2, 8'h80, 1'b0);
    rd(3'd2, 8'h00, 1'b0);
    rd(3'd2, 8'h00, 1'b1);
    rd(3'd2, 8'h00, 1'b0);
    sprite0_hit = 1'b1; rd(3'd2, 8'h40, 1'b0); sprite0_hit = 1'b0;
    sprite_ovf = 1'b1;  rd(3'd2, 8'h20, 1'b0); sprite_ovf = 1'b0;

    // NMI
    vblank_set = 1'b1; tick(); vblank_set = 1'b0; tick();
    chk("nmi_vblank_only", 32'(nmi), 32'(1));
    access(3'd0, 1'b1, 8'h80, 1'b0);
    chk("nmi_assert_c1", 32'(s_nmi), 32'(0));
    vblank_clr = 1'b1; tick(); vblank_clr = 1'b0;
    chk("nmi_release", 32'(nmi), 32'(1));
    access(3'd0, 1'b1, 8'h00, 1'b0);

    // STATUS read clears the write toggle
    access(3'd5, 1'b1, 8'hFF, 1'b0);
    rd(3'd2, 8'h00, 1'b0);
    access(3'd5, 1'b1, 8'h7D, 1'b0);
    chk("w_clr_t", 32'(vram_t[4:0]), 32'h0F);
    chk("w_clr_fx", 32'(fine_x), 32'(5));

    // OAM
    access(3'd3, 1'b1, 8'h10, 1'b0);
    access(3'd4, 1'b1, 8'hAB, 1'b0);
    chk("oam_we", 32'(s_oam_we), 32'(1));
    chk("oam_wr_addr", 32'(s_oam_addr), 32'h10);
    chk("oam_wr_data", 32'(s_oam_wd), 32'hAB);
    chk("oam_addr_inc", 32'(oam_addr), 32'h11);
    access(3'd3, 1'b1, 8'h10, 1'b0);
    rd(3'd4, 8'hAB, 1'b0);
    chk("oam_rd_noinc", 32'(oam_addr), 32'h10);
    rd(3'd1, 8'hAB, 1'b0);
    rd(3'd6, 8'hAB, 1'b0);

    // Reset mid-sequence, with cs held low across release
    access(3'd0, 1'b1, 8'h84, 1'b0);
    access(3'd6, 1'b1, 8'h21, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mrst_ppuctrl", 32'(ppuctrl), 32'(0));
    chk("mrst_vram_v", 32'(vram_v), 32'(0));
    chk("mrst_vram_t", 32'(vram_t), 32'(0));
    chk("mrst_fine_x", 32'(fine_x), 32'(0));
    chk("mrst_nmi", 32'(nmi), 32'(1));
    chk("mrst_rdata", 32'(reg_data_out), 32'(0));
    chk("mrst_oam_addr", 32'(oam_addr), 32'(0));
    chk("mrst_ppumask", 32'(ppumask), 32'(0));
    chk("mrst_strobes", 32'({vram_we, vram_re, oam_we}), 32'(0));
    ppu_reg_cs = 1'b0; ppu_reg_addr = 3'd0; reg_we = 1'b1; reg_data_in = 8'hFF;
    tick();
    @(posedge clk); #3 reset = 1'b0;
    tick(); tick(); tick();
    chk("no_commit_held_cs", 32'(ppuctrl), 32'(0));
    ppu_reg_cs = 1'b1;
    tick();
    access(3'd6, 1'b1, 8'h05, 1'b0);
    access(3'd6, 1'b1, 8'h06, 1'b0);
    chk("post_rst_v", 32'(vram_v), 32'h0506);
    rd(3'd7, 8'h00, 1'b0);
    tick(); tick();
    chk("vwr_drained", 32'(vwr_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
